lane_packer: RTL and testbench

- Downstream consumer of the masked-lane stream produced by the LF/HF compare-and-mask stage.
- Takes 128-bit RAM words plus a per-lane keep mask; real mode has 8 lanes of 16 bits, complex mode has 4 lanes of 32 bits.
- Discards the unkept lanes and packs the surviving lanes densely into full 128-bit output words for the next write-back/RAM stage.
- Marks the frame end and the fill level of the final word.

---
 rtl/lane_packer_pkg.sv | 25 ++
 rtl/lane_packer_if.sv | 28 ++
 rtl/lane_compress.sv | 40 ++++
 rtl/lane_packer.sv | 142 ++++++++++++++
 tb/tb_lane_packer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/lane_packer_pkg.sv
// Shared constants and types for the lane packer slice.
//   READ_RAM_WIDTH : data word width (input and packed output)
//   NUM / NUM_UNITS: 16-bit unit slots per word
//   CNT_W          : width of a unit count (0..NUM)
package lane_packer_pkg;

   localparam int unsigned READ_RAM_WIDTH = 128;
   localparam int unsigned NUM            = 8;
   localparam int unsigned DATA_WIDTH     = 16;

   localparam int unsigned NUM_UNITS = NUM;
   localparam int unsigned UNIT_W    = DATA_WIDTH;
   localparam int unsigned CNT_W     = $clog2(NUM) + 1;
   localparam int unsigned IDX_W     = $clog2(NUM);
   localparam int unsigned TOT_W     = CNT_W + 1;
   localparam int unsigned NUM_CPLX  = NUM / 2;
   localparam int unsigned BUF_W     = 2 * NUM_UNITS * UNIT_W;

   typedef enum logic {ACC = 1'b0, FLUSH = 1'b1} state_e;

   typedef enum logic {MODE_CPLX = 1'b0, MODE_REAL = 1'b1} lane_mode_e;

   typedef logic [NUM_UNITS-1:0][UNIT_W-1:0] units_t;

endpackage

// File: rtl/lane_packer_if.sv
// Masked-lane input stream and packed output stream of the lane packer.
//   slave  : packer side (consumes i_*, drives o_*)
//   master : upstream/downstream side (drives i_*, observes o_*)
interface lane_packer_if;
   import lane_packer_pkg::*;

   logic                      i_switch;
   logic [READ_RAM_WIDTH-1:0] i_x0;
   logic [NUM-1:0]            i_keep;
   logic                      i_x0_valid;
   logic                      i_last;
   logic                      o_ready;
   logic [READ_RAM_WIDTH-1:0] o_y0;
   logic                      o_y0_valid;
   logic                      o_y0_last;
   logic [CNT_W-1:0]          o_y0_cnt;

   modport slave (
      input  i_switch, i_x0, i_keep, i_x0_valid, i_last,
      output o_ready, o_y0, o_y0_valid, o_y0_last, o_y0_cnt
   );

   modport master (
      output i_switch, i_x0, i_keep, i_x0_valid, i_last,
      input  o_ready, o_y0, o_y0_valid, o_y0_last, o_y0_cnt
   );

endinterface

// File: rtl/lane_compress.sv
// Combinational compaction of the kept lanes of one word into contiguous units.
//   x       : input data word
//   keep    : per-lane keep mask (complex mode uses the low NUM/2 bits)
//   mode    : MODE_REAL (16-bit lanes) or MODE_CPLX (32-bit lanes)
//   units_c : kept units in ascending lane order, unused slots zero
//   k_c     : number of kept units
module lane_compress
   import lane_packer_pkg::*;
(
   input  logic [READ_RAM_WIDTH-1:0] x,
   input  logic [NUM-1:0]            keep,
   input  lane_mode_e                mode,
   output units_t                    units_c,
   output logic [CNT_W-1:0]          k_c
);

   // Running write position; k_c doubles as the position pointer.
   always_comb begin
      units_c = '0;
      k_c     = '0;
      if (mode == MODE_REAL) begin
         for (int i = 0; i < NUM; i++) begin
            if (keep[i]) begin
               units_c[k_c[IDX_W-1:0]] = x[i*UNIT_W +: UNIT_W];
               k_c = k_c + CNT_W'(1);
            end
         end
      end else begin
         // Complex position is always even, so the +1 slot never wraps.
         for (int j = 0; j < NUM_CPLX; j++) begin
            if (keep[j]) begin
               units_c[k_c[IDX_W-1:0]]               = x[(2*j)*UNIT_W +: UNIT_W];
               units_c[k_c[IDX_W-1:0] + IDX_W'(1)]   = x[(2*j+1)*UNIT_W +: UNIT_W];
               k_c = k_c + CNT_W'(2);
            end
         end
      end
   end

endmodule

// File: rtl/lane_packer.sv
// Packs the kept lanes of a masked-lane stream densely into full output words,
// marking frame end and the fill level of the final word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream interface (slave side)
module lane_packer
   import lane_packer_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   lane_packer_if.slave bus
);

   state_e                    state_q, state_d;
   logic [BUF_W-1:0]          buf_q, buf_d;
   logic [CNT_W-1:0]          fill_q, fill_d;
   lane_mode_e                mode_q, mode_d;
   logic                      open_q, open_d;
   logic [READ_RAM_WIDTH-1:0] y_q, y_d;
   logic                      valid_q, valid_d;
   logic                      last_q, last_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      ready_q, ready_d;

   lane_mode_e                mode_c;
   units_t                    units_c;
   logic [CNT_W-1:0]          k_c;
   logic                      accept_c;
   logic [BUF_W-1:0]          merged_c;
   logic [BUF_W-1:0]          upper_c;
   logic [TOT_W-1:0]          total_c;

   // Mode follows i_switch only on the opening beat of a frame.
   assign mode_c = open_q ? mode_q : lane_mode_e'(bus.i_switch);

   lane_compress u_compress (
      .x       (bus.i_x0),
      .keep    (bus.i_keep),
      .mode    (mode_c),
      .units_c (units_c),
      .k_c     (k_c)
   );

   // Slots at and above fill are kept zero, so OR-append is exact.
   assign accept_c = bus.i_x0_valid && (state_q == ACC);
   assign merged_c = buf_q | (BUF_W'(units_c) << (fill_q * UNIT_W));
   assign upper_c  = merged_c >> (NUM_UNITS * UNIT_W);
   assign total_c  = TOT_W'(fill_q) + TOT_W'(k_c);

   // Next-state, buffer update and output word formation.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
      mode_d  = mode_q;
      open_d  = open_q;
      y_d     = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      cnt_d   = '0;
      case (state_q)
         ACC: begin
            if (accept_c) begin
               mode_d = mode_c;
               if (!bus.i_last) begin
                  open_d = 1'b1;
                  if (total_c >= TOT_W'(NUM)) begin
                     y_d     = merged_c[READ_RAM_WIDTH-1:0];
                     valid_d = 1'b1;
                     cnt_d   = CNT_W'(NUM);
                     buf_d   = upper_c;
                     fill_d  = CNT_W'(total_c - TOT_W'(NUM));
                  end else begin
                     buf_d  = merged_c;
                     fill_d = CNT_W'(total_c);
                  end
               end else begin
                  open_d  = 1'b0;
                  valid_d = 1'b1;
                  y_d     = merged_c[READ_RAM_WIDTH-1:0];
                  if (total_c > TOT_W'(NUM)) begin
                     cnt_d   = CNT_W'(NUM);
                     buf_d   = upper_c;
                     fill_d  = CNT_W'(total_c - TOT_W'(NUM));
                     state_d = FLUSH;
                  end else begin
                     last_d = 1'b1;
                     cnt_d  = CNT_W'(total_c);
                     buf_d  = '0;
                     fill_d = '0;
                  end
               end
            end
         end
         FLUSH: begin
            // Remainder of an overflowing last beat; input is stalled here.
            y_d     = buf_q[READ_RAM_WIDTH-1:0];
            valid_d = 1'b1;
            last_d  = 1'b1;
            cnt_d   = fill_q;
            buf_d   = '0;
            fill_d  = '0;
            state_d = ACC;
         end
         default: state_d = ACC;
      endcase
      ready_d = (state_d == ACC);
   end

   // State, residual store and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         buf_q   <= '0;
         fill_q  <= '0;
         mode_q  <= MODE_CPLX;
         open_q  <= 1'b0;
         y_q     <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         mode_q  <= mode_d;
         open_q  <= open_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   assign bus.o_ready    = ready_q;
   assign bus.o_y0       = y_q;
   assign bus.o_y0_valid = valid_q;
   assign bus.o_y0_last  = last_q;
   assign bus.o_y0_cnt   = cnt_q;

endmodule

// File: tb/tb_lane_packer.sv
// Self-checking bench for lane_packer: directed frames plus random frames,
// checked against a unit-queue reference model.
module tb_lane_packer;
   import lane_packer_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   lane_packer_if bus ();

   lane_packer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0]     y;
      logic             last;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic [15:0] uq[$];
   exp_t        eq[$];
   bit          open_f;
   bit          mode_real;
   bit          exp_ready;
   int          checks;
   int          errors;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      uq.delete();
      eq.delete();
      open_f    = 1'b0;
      mode_real = 1'b0;
      exp_ready = 1'b1;
   endtask

   // Pop n units from the unit queue into one expected word.
   task automatic emit(input int n, input logic last);
      exp_t e;
      e.y = '0;
      for (int i = 0; i < n; i++) e.y[i*16 +: 16] = uq.pop_front();
      e.last = last;
      e.cnt  = CNT_W'(n);
      eq.push_back(e);
   endtask

   task automatic model_accept(input logic sw, input logic [127:0] x,
                               input logic [7:0] keep, input logic last);
      if (!open_f) mode_real = sw;
      if (mode_real) begin
         for (int i = 0; i < 8; i++)
            if (keep[i]) uq.push_back(x[i*16 +: 16]);
      end else begin
         for (int j = 0; j < 4; j++)
            if (keep[j]) begin
               uq.push_back(x[j*32 +: 16]);
               uq.push_back(x[j*32+16 +: 16]);
            end
      end
      if (!last) begin
         open_f = 1'b1;
         while (uq.size() >= 8) emit(8, 1'b0);
      end else begin
         open_f = 1'b0;
         if (uq.size() > 8) exp_ready = 1'b0;
         while (uq.size() > 8) emit(8, 1'b0);
         emit(uq.size(), 1'b1);
      end
   endtask

   task automatic check_outputs(input string tag);
      exp_t e;
      bit   want;
      want = (eq.size() != 0);
      chk({tag, "_valid"}, 128'(bus.o_y0_valid), 128'(want));
      if (bus.o_y0_valid === 1'b1 && want) begin
         e = eq.pop_front();
         chk({tag, "_y0"},   bus.o_y0,            e.y);
         chk({tag, "_last"}, 128'(bus.o_y0_last), 128'(e.last));
         chk({tag, "_cnt"},  128'(bus.o_y0_cnt),  128'(e.cnt));
      end
      chk({tag, "_ready"}, 128'(bus.o_ready), 128'(exp_ready));
   endtask

   // One clock: drive, edge, update model, check. Entered/left at edge+1.
   task automatic cycle(input string tag, input logic sw, input logic [127:0] x,
                        input logic [7:0] keep, input logic valid, input logic last,
                        output bit acc);
      bit rdy;
      bus.i_switch   = sw;
      bus.i_x0       = x;
      bus.i_keep     = keep;
      bus.i_x0_valid = valid;
      bus.i_last     = last;
      rdy = exp_ready;
      @(posedge clk);
      acc = valid && rdy;
      #1;
      exp_ready = 1'b1;
      if (acc) model_accept(sw, x, keep, last);
      check_outputs(tag);
   endtask

   task automatic beat(input string tag, input logic sw, input logic [127:0] x,
                       input logic [7:0] keep, input logic last);
      bit acc;
      acc = 1'b0;
      for (int t = 0; t < 4 && !acc; t++) cycle(tag, sw, x, keep, 1'b1, last, acc);
   endtask

   task automatic idle(input string tag, input int n);
      bit acc;
      for (int t = 0; t < n; t++)
         cycle(tag, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
               8'($urandom), 1'b0, 1'($urandom), acc);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_y0"},    bus.o_y0,             128'd0);
      chk({tag, "_valid"}, 128'(bus.o_y0_valid), 128'd0);
      chk({tag, "_last"},  128'(bus.o_y0_last),  128'd0);
      chk({tag, "_cnt"},   128'(bus.o_y0_cnt),   128'd0);
      chk({tag, "_ready"}, 128'(bus.o_ready),    128'd1);
   endtask

   function automatic logic [127:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] x;
      checks = 0;
      errors = 0;
      model_reset();
      bus.i_switch   = 1'b0;
      bus.i_x0       = '0;
      bus.i_keep     = '0;
      bus.i_x0_valid = 1'b0;
      bus.i_last     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst_n = 1'b1;

      // Real, all lanes kept: words pass through unchanged.
      for (int b = 0; b < 3; b++) beat("real_ff", 1'b1, rnd_word(), 8'hFF, 1'(b == 2));
      idle("real_ff_idle", 2);

      // Real, half lanes kept twice: units 1..8 packed in order.
      x = rnd_word();
      for (int i = 0; i < 4; i++) x[i*16 +: 16] = 16'(i + 1);
      beat("real_0f_a", 1'b1, x, 8'h0F, 1'b0);
      x = rnd_word();
      for (int i = 0; i < 4; i++) x[i*16 +: 16] = 16'(i + 5);
      beat("real_0f_b", 1'b1, x, 8'h0F, 1'b1);
      idle("real_0f_idle", 2);

      // Real overflow on last beat: full word, one stall, then 6-unit tail.
      beat("ovf_a", 1'b1, rnd_word(), 8'h3F, 1'b0);
      beat("ovf_b", 1'b1, rnd_word(), 8'hFF, 1'b1);
      idle("ovf_idle", 3);

      // Complex, lanes 0 and 2 kept; mid-frame i_switch flips are ignored.
      beat("cplx_a", 1'b0, rnd_word(), 8'hF5, 1'b0);
      beat("cplx_b", 1'b1, rnd_word(), 8'hA5, 1'b0);
      beat("cplx_c", 1'b1, rnd_word(), 8'h05, 1'b1);
      idle("cplx_idle", 3);

      // Empty last beat: zero-count frame-end marker.
      beat("empty", 1'b1, rnd_word(), 8'h00, 1'b1);
      idle("empty_idle", 2);

      // Reset with five units buffered: nothing leaks into the next frame.
      beat("pre_rst", 1'b1, rnd_word(), 8'h1F, 1'b0);
      rst_n = 1'b0;
      #2;
      check_reset_state("mid_rst");
      model_reset();
      rst_n = 1'b1;
      idle("post_rst_idle", 1);
      beat("post_rst", 1'b1, rnd_word(), 8'hFF, 1'b1);
      idle("post_rst_idle2", 2);

      // Random frames with random gaps, modes and masks.
      for (int f = 0; f < 40; f++) begin
         int nb;
         nb = 1 + int'($urandom_range(0, 5));
         for (int b = 0; b < nb; b++) begin
            logic [7:0] keep;
            logic       sw;
            bit         acc;
            keep = 8'($urandom);
            if ($urandom_range(0, 5) == 0) keep = 8'h00;
            sw = 1'($urandom);
            x  = rnd_word();
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++)
               cycle("rand", sw, x, keep, 1'($urandom_range(0, 3) != 0), 1'(b == nb - 1), acc);
         end
         if ($urandom_range(0, 2) == 0) idle("rand_idle", 1 + int'($urandom_range(0, 2)));
      end
      idle("drain", 3);
      chk("pending_words", 128'(eq.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
